// File: rtl/cpu_selfcheck_pkg.sv
// Shared types for the writeback self-check monitor.
// Optional PC trace checking is built when SELFCHECK_PC_TRACE_EN is defined.
package cpu_selfcheck_pkg;

  localparam logic [4:0] X0 = 5'd0;

  // Widest supported datapath; narrower cores zero-extend into it.
  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_MAX-1:0] value;
  } chk_entry_t;

endpackage

// File: rtl/selfcheck_watchdog.sv
// Loadable, clearable up-counter; expire flags the increment that hits LIMIT.
// Shared by the self-check monitors.
module selfcheck_watchdog #(
  parameter  int LIMIT = 1024,
  localparam int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         expire
);

  assign expire = inc && !clr && !load
                  && (count == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cpu_selfcheck_monitor.sv
// Writeback self-check monitor: ordered (rd, value) table, counters, watchdog.
// Define SELFCHECK_PC_TRACE_EN to also check the PC sequence during a run.
module cpu_selfcheck_monitor
  import cpu_selfcheck_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int NUM_CHECKS     = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int AW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CW = $clog2(NUM_CHECKS + 1),
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            chk_we,
  input  logic [AW-1:0]   chk_addr,
  input  logic [4:0]      chk_rd,
  input  logic [XLEN-1:0] chk_value,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_redirect,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [CW-1:0]   pass_count,
  output logic [CW-1:0]   fail_count,
  output logic [AW-1:0]   first_fail_idx,
  output logic [15:0]     pc_err_count
);

  state_e        state_q;
  chk_entry_t    tbl_q [NUM_CHECKS];
  chk_entry_t    cur;
  logic [CW-1:0] idx_q;
  logic          run;
  logic          enter;
  logic          hit;
  logic          match;
  logic          last;
  logic          wd_exp;
  logic [TW-1:0] wd_count_unused;

  assign run   = state_q == RUN;
  assign enter = start && !run;
  assign cur   = tbl_q[idx_q[AW-1:0]];
  assign hit   = run && wb_valid && (wb_rd != X0)
                 && (wb_rd == cur.rd);
  assign match = cur.value == XLEN_MAX'(wb_data);
  assign last  = idx_q == CW'(NUM_CHECKS - 1);

  assign busy = run;
  assign done = state_q == DONE;
  assign pass = done && (fail_count == '0)
                && !timeout && (pc_err_count == '0);

  // Table has no reset so expectations survive a core reset.
  always_ff @(posedge clk) begin
    if (chk_we && !run) begin
      tbl_q[chk_addr] <= '{rd: chk_rd,
                           value: XLEN_MAX'(chk_value)};
    end
  end

  selfcheck_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clr      (enter || hit),
    .load     (1'b0),
    .load_val ('0),
    .inc      (run && !hit),
    .count    (wd_count_unused),
    .expire   (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      timeout        <= 1'b0;
    end else if (enter) begin
      state_q        <= RUN;
      idx_q          <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      timeout        <= 1'b0;
    end else if (hit) begin
      idx_q <= idx_q + CW'(1);
      if (match) begin
        pass_count <= pass_count + CW'(1);
      end else begin
        fail_count <= fail_count + CW'(1);
        if (fail_count == '0) begin
          first_fail_idx <= idx_q[AW-1:0];
        end
      end
      if (last) begin
        state_q <= DONE;
      end
    end else if (wd_exp) begin
      // Every check still outstanding counts as failed.
      timeout    <= 1'b1;
      fail_count <= fail_count + (CW'(NUM_CHECKS) - idx_q);
      if (fail_count == '0) begin
        first_fail_idx <= idx_q[AW-1:0];
      end
      state_q <= DONE;
    end
  end

`ifdef SELFCHECK_PC_TRACE_EN
  logic [XLEN-1:0] prev_pc_q;
  logic            prev_redir_q;
  logic            prev_run_q;
  logic            pc_bad;

  // A stall (pc unchanged) or a prior redirect is never an error.
  assign pc_bad = run && prev_run_q && !prev_redir_q
                  && (pc != prev_pc_q)
                  && (pc != prev_pc_q + XLEN'(4));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_q    <= '0;
      prev_redir_q <= 1'b0;
      prev_run_q   <= 1'b0;
      pc_err_count <= '0;
    end else begin
      prev_pc_q    <= pc;
      prev_redir_q <= pc_redirect;
      prev_run_q   <= run;
      if (enter) begin
        pc_err_count <= '0;
      end else if (pc_bad && pc_err_count != 16'hFFFF) begin
        pc_err_count <= pc_err_count + 16'd1;
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc    = ^{pc, pc_redirect};
  assign pc_err_count = '0;
`endif

endmodule

// File: tb/tb_cpu_selfcheck_monitor.sv
// Bench for cpu_selfcheck_monitor: vector table plus multi-cycle sequences,
// with expected run results queued at stimulus time and checked at done.
module tb_cpu_selfcheck_monitor;

  localparam int NC = 3;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        chk_we;
  logic [1:0]  chk_addr;
  logic [4:0]  chk_rd;
  logic [31:0] chk_value;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pc;
  logic        pc_redirect;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [1:0]  pass_count;
  logic [1:0]  fail_count;
  logic [1:0]  first_fail_idx;
  logic [15:0] pc_err_count;

  cpu_selfcheck_monitor #(
    .XLEN           (32),
    .NUM_CHECKS     (NC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .chk_we         (chk_we),
    .chk_addr       (chk_addr),
    .chk_rd         (chk_rd),
    .chk_value      (chk_value),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .pc             (pc),
    .pc_redirect    (pc_redirect),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .pc_err_count   (pc_err_count)
  );

  always #5 clk = ~clk;

  // ffi < 0 means first_fail_idx is not compared.
  typedef struct packed {
    int pc;
    int fc;
    int ffi;
    int ps;
    int to;
    int pe;
  } exp_t;

  typedef struct packed {
    logic [2:0][4:0]  trd;
    logic [2:0][31:0] tval;
    int               wn;
    logic [4:0]       wv;
    logic [4:0][4:0]  wrd;
    logic [4:0][31:0] wd;
    exp_t             e;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [4:0] rd,
                      input logic [31:0] v);
    chk_we    = 1'b1;
    chk_addr  = a;
    chk_rd    = rd;
    chk_value = v;
    tick();
    chk_we = 1'b0;
  endtask

  task automatic load3(input logic [2:0][4:0] rd,
                       input logic [2:0][31:0] v);
    for (int k = 0; k < NC; k++) begin
      load(2'(k), rd[k], v[k]);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd,
                    input logic [31:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s.done_wait: got 0, want 1 within 100 cycles", nm);
    end
  endtask

  task automatic check_sb(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s.scoreboard: got empty queue, want entry", nm);
      return;
    end
    e = sbq.pop_front();
    chk({nm, ".pass_count"}, int'(pass_count), e.pc);
    chk({nm, ".fail_count"}, int'(fail_count), e.fc);
    if (e.ffi >= 0 && e.fc != 0) begin
      chk({nm, ".first_fail_idx"}, int'(first_fail_idx), e.ffi);
    end
    chk({nm, ".pass"}, int'(pass), e.ps);
    chk({nm, ".timeout"}, int'(timeout), e.to);
    chk({nm, ".pc_err_count"}, int'(pc_err_count), e.pe);
    chk({nm, ".busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    chk_we      = 1'b0;
    chk_addr    = '0;
    chk_rd      = '0;
    chk_value   = '0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    pc          = '0;
    pc_redirect = 1'b0;

    vecs[0].trd  = {5'd3, 5'd2, 5'd1};
    vecs[0].tval = {32'd6, 32'd3, 32'd1};
    vecs[0].wn   = 4;
    vecs[0].wv   = 5'b01111;
    vecs[0].wrd  = {5'd0, 5'd3, 5'd2, 5'd5, 5'd1};
    vecs[0].wd   = {32'd0, 32'd6, 32'd3, 32'd9, 32'd1};
    vecs[0].e    = '{3, 0, 0, 1, 0, 0};

    vecs[1].trd  = {5'd3, 5'd2, 5'd1};
    vecs[1].tval = {32'd6, 32'd3, 32'd1};
    vecs[1].wn   = 3;
    vecs[1].wv   = 5'b00111;
    vecs[1].wrd  = {5'd0, 5'd0, 5'd3, 5'd2, 5'd1};
    vecs[1].wd   = {32'd0, 32'd0, 32'd6, 32'd4, 32'd1};
    vecs[1].e    = '{2, 1, 1, 0, 0, 0};

    vecs[2].trd  = {5'd3, 5'd2, 5'd1};
    vecs[2].tval = {32'd6, 32'd3, 32'd1};
    vecs[2].wn   = 3;
    vecs[2].wv   = 5'b00111;
    vecs[2].wrd  = {5'd0, 5'd0, 5'd3, 5'd2, 5'd1};
    vecs[2].wd   = {32'd0, 32'd0, 32'd7, 32'd3, 32'd2};
    vecs[2].e    = '{1, 2, 0, 0, 0, 0};

    vecs[3].trd  = {5'd31, 5'd4, 5'd4};
    vecs[3].tval = {32'hFFFF_FFFF, 32'd1, 32'hDEAD_BEEF};
    vecs[3].wn   = 5;
    vecs[3].wv   = 5'b11011;
    vecs[3].wrd  = {5'd31, 5'd4, 5'd4, 5'd0, 5'd4};
    vecs[3].wd   = {32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1, 32'hDEAD_BEEF};
    vecs[3].e    = '{3, 0, 0, 1, 0, 0};

    vecs[4].trd  = {5'd12, 5'd11, 5'd10};
    vecs[4].tval = {32'hC, 32'hB, 32'hA};
    vecs[4].wn   = 3;
    vecs[4].wv   = 5'b00111;
    vecs[4].wrd  = {5'd0, 5'd0, 5'd12, 5'd11, 5'd10};
    vecs[4].wd   = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[4].e    = '{0, 3, 0, 0, 0, 0};

    tick();
    tick();
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.pass", int'(pass), 0);
    chk("reset.timeout", int'(timeout), 0);
    chk("reset.pass_count", int'(pass_count), 0);
    chk("reset.fail_count", int'(fail_count), 0);
    chk("reset.first_fail_idx", int'(first_fail_idx), 0);
    chk("reset.pc_err_count", int'(pc_err_count), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      load3(vecs[i].trd, vecs[i].tval);
      sbq.push_back(vecs[i].e);
      start_run();
      chk({nm, ".busy_after_start"}, int'(busy), 1);
      for (int j = 0; j < vecs[i].wn; j++) begin
        wb(vecs[i].wv[j], vecs[i].wrd[j], vecs[i].wd[j]);
      end
      wait_done(nm);
      check_sb(nm);
    end

    // Reset mid-run, then rerun on the retained table.
    load3({5'd3, 5'd2, 5'd1}, {32'd6, 32'd3, 32'd1});
    start_run();
    wb(1'b1, 5'd1, 32'd1);
    chk("midreset.pass_before", int'(pass_count), 1);
    reset = 1'b1;
    tick();
    chk("midreset.busy", int'(busy), 0);
    chk("midreset.done", int'(done), 0);
    chk("midreset.pass_count", int'(pass_count), 0);
    reset = 1'b0;
    sbq.push_back('{3, 0, 0, 1, 0, 0});
    start_run();
    wb(1'b1, 5'd1, 32'd1);
    wb(1'b1, 5'd2, 32'd3);
    wb(1'b1, 5'd3, 32'd6);
    wait_done("retained");
    check_sb("retained");
    tick();
    tick();
    chk("done_holds", int'(done), 1);

    // chk_we and start during RUN are ignored.
    sbq.push_back('{3, 0, 0, 1, 0, 0});
    start_run();
    wb(1'b1, 5'd1, 32'd1);
    start     = 1'b1;
    chk_we    = 1'b1;
    chk_addr  = 2'd2;
    chk_rd    = 5'd3;
    chk_value = 32'd99;
    tick();
    start  = 1'b0;
    chk_we = 1'b0;
    chk("run_ignores_start", int'(pass_count), 1);
    wb(1'b1, 5'd2, 32'd3);
    wb(1'b1, 5'd3, 32'd6);
    wait_done("run_ignores_we");
    check_sb("run_ignores_we");

    // Write and start in the same cycle: the run sees the new entry.
    sbq.push_back('{3, 0, 0, 1, 0, 0});
    start     = 1'b1;
    chk_we    = 1'b1;
    chk_addr  = 2'd0;
    chk_rd    = 5'd7;
    chk_value = 32'd42;
    tick();
    start  = 1'b0;
    chk_we = 1'b0;
    wb(1'b1, 5'd1, 32'd1);
    chk("we_start.old_entry", int'(pass_count), 0);
    wb(1'b1, 5'd7, 32'd42);
    wb(1'b1, 5'd2, 32'd3);
    wb(1'b1, 5'd3, 32'd6);
    wait_done("we_start");
    check_sb("we_start");

    // Watchdog with no writebacks: done exactly TO cycles into RUN.
    load3({5'd3, 5'd2, 5'd1}, {32'd6, 32'd3, 32'd1});
    sbq.push_back('{0, 3, -1, 0, 1, 0});
    start_run();
    repeat (TO - 1) tick();
    chk("timeout.early_done", int'(done), 0);
    chk("timeout.early_flag", int'(timeout), 0);
    tick();
    chk("timeout.done_at_limit", int'(done), 1);
    check_sb("timeout_all");

    // One pass, then the watchdog fails the remaining two.
    sbq.push_back('{1, 2, -1, 0, 1, 0});
    start_run();
    chk("timeout2.cleared", int'(timeout), 0);
    wb(1'b1, 5'd1, 32'd1);
    wait_done("timeout_part");
    check_sb("timeout_part");

    // x0 entry can never be consumed, so idx stays 0 until timeout.
    load3({5'd2, 5'd1, 5'd0}, {32'd3, 32'd1, 32'd5});
    sbq.push_back('{0, 3, -1, 0, 1, 0});
    start_run();
    wb(1'b1, 5'd0, 32'd5);
    chk("x0.pass_count", int'(pass_count), 0);
    chk("x0.fail_count", int'(fail_count), 0);
    wb(1'b1, 5'd1, 32'd1);
    chk("x0.idx_stuck", int'(pass_count), 0);
    wait_done("x0");
    check_sb("x0");

`ifdef SELFCHECK_PC_TRACE_EN
    load3({5'd3, 5'd2, 5'd1}, {32'd6, 32'd3, 32'd1});
    sbq.push_back('{3, 0, 0, 0, 0, 1});
    start_run();
    pc = 32'h0;
    tick();
    pc = 32'h4;
    tick();
    pc = 32'h8;
    tick();
    pc = 32'h14;
    tick();
    wb(1'b1, 5'd1, 32'd1);
    wb(1'b1, 5'd2, 32'd3);
    wb(1'b1, 5'd3, 32'd6);
    wait_done("pc_jump");
    check_sb("pc_jump");

    sbq.push_back('{3, 0, 0, 1, 0, 0});
    start_run();
    pc = 32'h0;
    tick();
    pc = 32'h4;
    tick();
    pc          = 32'h8;
    pc_redirect = 1'b1;
    tick();
    pc          = 32'h10;
    pc_redirect = 1'b0;
    tick();
    wb(1'b1, 5'd1, 32'd1);
    wb(1'b1, 5'd2, 32'd3);
    wb(1'b1, 5'd3, 32'd6);
    wait_done("pc_redirect");
    check_sb("pc_redirect");
    pc = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
